// File: rtl/multi_button_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_button_debouncer_pkg
// Description : State encoding and width helper for the button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_button_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } btnState_t;

    // Ceiling log2 with a minimum result of 1 so counters never get zero width.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_button_debouncer_button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : Synchroniser, tick-qualified debounce and press/long FSM for
//               one button in the pressed=1 domain.
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import multi_button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int DEB_COUNT   = 4,
    parameter int LONG_COUNT  = 100
) (
    input  logic Clk,
    input  logic Rst,
    input  logic ClkEnable,
    input  logic RawIn,
    output logic Level,
    output logic PressPulse,
    output logic ReleasePulse,
    output logic LongPulse
);

    localparam int DEB_W  = clog2(DEB_COUNT + 1);
    localparam int HOLD_W = clog2(LONG_COUNT + 1);
    localparam logic [DEB_W-1:0]  c_DEB_LAST  = DEB_W'(DEB_COUNT - 1);
    localparam logic [HOLD_W-1:0] c_LONG_LAST = HOLD_W'(LONG_COUNT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_debCnt;
    logic [HOLD_W-1:0]      r_hold;
    btnState_t              r_state;

    logic w_sample;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    assign w_sample = r_sync[SYNC_STAGES-1];
    // Level flips on this edge when the last needed disagreeing tick arrives.
    assign w_flip   = ClkEnable && (w_sample != Level) && (r_debCnt == c_DEB_LAST);
    assign w_rise   = w_flip && w_sample;
    assign w_fall   = w_flip && !w_sample;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], RawIn};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_debCnt     <= '0;
            r_hold       <= '0;
            r_state      <= RELEASED;
            Level        <= 1'b0;
            PressPulse   <= 1'b0;
            ReleasePulse <= 1'b0;
            LongPulse    <= 1'b0;
        end else begin
            PressPulse   <= w_rise;
            ReleasePulse <= w_fall;
            LongPulse    <= 1'b0;

            if (ClkEnable) begin
                if (w_sample == Level) begin
                    r_debCnt <= '0;
                end else if (r_debCnt == c_DEB_LAST) begin
                    Level    <= w_sample;
                    r_debCnt <= '0;
                end else begin
                    r_debCnt <= r_debCnt + DEB_W'(1);
                end

                case (r_state)
                    RELEASED: begin
                        if (w_rise) begin
                            r_state <= PRESSED;
                            r_hold  <= '0;
                        end
                    end
                    PRESSED: begin
                        // A release on the same tick suppresses the long event.
                        if (w_fall) begin
                            r_state <= RELEASED;
                        end else if (r_hold == c_LONG_LAST) begin
                            LongPulse <= 1'b1;
                            r_state   <= LONG;
                        end else begin
                            r_hold <= r_hold + HOLD_W'(1);
                        end
                    end
                    LONG: begin
                        if (w_fall) begin
                            r_state <= RELEASED;
                        end
                    end
                    default: begin
                        r_state <= RELEASED;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : multi_button_debouncer
// Description : NUM_BTN independent debounced buttons with level, press,
//               release and long-press outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_button_debouncer
    import multi_button_debouncer_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int SYNC_STAGES = 3,
    parameter int DEB_COUNT   = 4,
    parameter int LONG_COUNT  = 100,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               ClkEnable,
    input  logic [NUM_BTN-1:0] ButtonIn,
    output logic [NUM_BTN-1:0] Level,
    output logic [NUM_BTN-1:0] PressPulse,
    output logic [NUM_BTN-1:0] ReleasePulse,
    output logic [NUM_BTN-1:0] LongPulse
);

    localparam logic c_INVERT = (ACTIVE_LOW != 0);

    logic [NUM_BTN-1:0] w_raw;

    assign w_raw = ButtonIn ^ {NUM_BTN{c_INVERT}};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_channel
        button_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_COUNT   (DEB_COUNT),
            .LONG_COUNT  (LONG_COUNT)
        ) u_channel (
            .Clk          (Clk),
            .Rst          (Rst),
            .ClkEnable    (ClkEnable),
            .RawIn        (w_raw[i]),
            .Level        (Level[i]),
            .PressPulse   (PressPulse[i]),
            .ReleasePulse (ReleasePulse[i]),
            .LongPulse    (LongPulse[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_button_debouncer
// Description : Directed self-checking bench for multi_button_debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multi_button_debouncer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       ClkEnable = 1'b1;
    logic [1:0] ButtonIn = 2'b00;
    logic [1:0] ButtonInLow = 2'b11;
    logic [1:0] Level, PressPulse, ReleasePulse, LongPulse;
    logic [1:0] LevelLow, PressPulseLow, ReleasePulseLow, LongPulseLow;

    int checks = 0;
    int passes = 0;

    always #5 Clk = ~Clk;

    multi_button_debouncer #(
        .NUM_BTN(2), .SYNC_STAGES(2), .DEB_COUNT(4), .LONG_COUNT(8), .ACTIVE_LOW(0)
    ) dut (
        .Clk(Clk), .Rst(Rst), .ClkEnable(ClkEnable), .ButtonIn(ButtonIn),
        .Level(Level), .PressPulse(PressPulse),
        .ReleasePulse(ReleasePulse), .LongPulse(LongPulse)
    );

    multi_button_debouncer #(
        .NUM_BTN(2), .SYNC_STAGES(2), .DEB_COUNT(4), .LONG_COUNT(8), .ACTIVE_LOW(1)
    ) dutLow (
        .Clk(Clk), .Rst(Rst), .ClkEnable(ClkEnable), .ButtonIn(ButtonInLow),
        .Level(LevelLow), .PressPulse(PressPulseLow),
        .ReleasePulse(ReleasePulseLow), .LongPulse(LongPulseLow)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        ButtonIn    = 2'b00;
        ButtonInLow = 2'b11;
        ClkEnable   = 1'b1;
        Rst         = 1'b1;
        step();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        Rst = 1'b1;
        step();
        step();
        for (int e = 1; e <= 4; e++) begin
            obs = {Level, PressPulse, ReleasePulse, LongPulse};
            checks++;
            if (obs !== 8'h00) $display("FAIL reset_main step %0d: got %b expected %b", e, obs, 8'h00);
            else passes++;
            obs = {LevelLow, PressPulseLow, ReleasePulseLow, LongPulseLow};
            checks++;
            if (obs !== 8'h00) $display("FAIL reset_low step %0d: got %b expected %b", e, obs, 8'h00);
            else passes++;
            Rst = 1'b0;
            step();
        end
    endtask

    task automatic test_clean_press();
        logic [7:0] obs, exp;
        doReset();
        ButtonIn = 2'b01;
        for (int e = 1; e <= 9; e++) begin
            step();
            exp = {(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00};
            obs = {Level, PressPulse, ReleasePulse, LongPulse};
            checks++;
            if (obs !== exp) $display("FAIL clean_press edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_bounce();
        logic [7:0] obs, exp;
        doReset();
        for (int e = 1; e <= 22; e++) begin
            ButtonIn[0] = (e >= 13) ? 1'b1 : ((((e - 1) / 3) % 2) == 0);
            step();
            exp = {(e >= 18) ? 2'b01 : 2'b00, (e == 18) ? 2'b01 : 2'b00, 2'b00, 2'b00};
            obs = {Level, PressPulse, ReleasePulse, LongPulse};
            checks++;
            if (obs !== exp) $display("FAIL bounce edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_long_press();
        logic [7:0] obs, exp;
        doReset();
        for (int e = 1; e <= 52; e++) begin
            ButtonIn = (e < 40) ? 2'b01 : 2'b00;
            step();
            exp = {(e >= 6 && e < 45) ? 2'b01 : 2'b00,
                   (e == 6)  ? 2'b01 : 2'b00,
                   (e == 45) ? 2'b01 : 2'b00,
                   (e == 14) ? 2'b01 : 2'b00};
            obs = {Level, PressPulse, ReleasePulse, LongPulse};
            checks++;
            if (obs !== exp) $display("FAIL long_press edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_tick_gating();
        logic [7:0] obs, exp;
        doReset();
        ButtonIn = 2'b01;
        for (int e = 1; e <= 45; e++) begin
            ClkEnable = ((e % 10) == 0);
            step();
            exp = {(e >= 40) ? 2'b01 : 2'b00, (e == 40) ? 2'b01 : 2'b00, 2'b00, 2'b00};
            obs = {Level, PressPulse, ReleasePulse, LongPulse};
            checks++;
            if (obs !== exp) $display("FAIL tick_gating edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
        ClkEnable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs, exp;
        doReset();
        ButtonIn = 2'b01;
        for (int e = 1; e <= 13; e++) begin
            Rst = (e == 5);
            step();
            exp = {(e >= 11) ? 2'b01 : 2'b00, (e == 11) ? 2'b01 : 2'b00, 2'b00, 2'b00};
            obs = {Level, PressPulse, ReleasePulse, LongPulse};
            checks++;
            if (obs !== exp) $display("FAIL reset_debounce edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
        Rst = 1'b0;
        doReset();
        ButtonIn = 2'b01;
        for (int e = 1; e <= 28; e++) begin
            Rst = (e == 12);
            step();
            exp = {((e >= 6 && e < 12) || e >= 18) ? 2'b01 : 2'b00,
                   (e == 6 || e == 18) ? 2'b01 : 2'b00,
                   2'b00,
                   (e == 26) ? 2'b01 : 2'b00};
            obs = {Level, PressPulse, ReleasePulse, LongPulse};
            checks++;
            if (obs !== exp) $display("FAIL reset_hold edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
        Rst = 1'b0;
    endtask

    task automatic test_active_low();
        logic [7:0] obs, exp;
        doReset();
        ButtonInLow = 2'b00;
        for (int e = 1; e <= 9; e++) begin
            step();
            exp = {(e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00};
            obs = {LevelLow, PressPulseLow, ReleasePulseLow, LongPulseLow};
            checks++;
            if (obs !== exp) $display("FAIL active_low edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
            obs = {Level, PressPulse, ReleasePulse, LongPulse};
            checks++;
            if (obs !== 8'h00) $display("FAIL active_low_other edge %0d: got %b expected %b", e, obs, 8'h00);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_tick_gating();
        test_reset_mid();
        test_active_low();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
